// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: frame-driven RAM controller behind an SPI serial-to-parallel
// stage. Each 10-bit frame carries a 2-bit command and an 8-bit payload that
// either sets a write/read pointer, writes a byte, or reads a byte back.
// Every response (memory write, tx_valid, err) appears one clock after the
// frame strobe.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [9:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       err
);

  typedef enum logic [1:0] {
    CMD_SET_WA  = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_SET_RA  = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // The armed state encodes which address registers hold a valid pointer.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WR_ARMED   = 2'b01,
    RD_ARMED   = 2'b10,
    BOTH_ARMED = 2'b11
  } state_e;

  // Reject configurations where the address register cannot cover the memory.
  generate
    if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_bad_cfg
      $error("spi_ram_ctrl: illegal MEM_DEPTH/ADDR_SIZE combination");
    end
  endgenerate

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [8:0]           DEPTH_9   = 9'(MEM_DEPTH);

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   err_q, err_d;
  logic [7:0]             mem_q [MEM_DEPTH];

  cmd_e                   cmd;
  logic [7:0]             payload;
  logic                   payload_ok;
  logic [ADDR_SIZE-1:0]   payload_addr;
  logic                   wa_set, ra_set;
  logic                   mem_we;
  logic [7:0]             rd_word;
  logic [IDX_W-1:0]       wr_idx, rd_idx;

  // Frame fields and derived flags.
  always_comb begin
    cmd          = cmd_e'(rx_data[9:8]);
    payload      = rx_data[7:0];
    payload_ok   = ({1'b0, payload} < DEPTH_9);
    payload_addr = ADDR_SIZE'(payload);
    wa_set       = (state_q == WR_ARMED) || (state_q == BOTH_ARMED);
    ra_set       = (state_q == RD_ARMED) || (state_q == BOTH_ARMED);
    // Pointers never exceed MEM_DEPTH-1, so the upper bits are always zero.
    wr_idx       = wr_addr_q[IDX_W-1:0];
    rd_idx       = rd_addr_q[IDX_W-1:0];
    rd_word      = mem_q[rd_idx];
  end

  // Frame decode: next-state, pointer updates and one-cycle response strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    if (rx_valid) begin
      unique case (cmd)
        CMD_SET_WA: begin
          if (payload_ok) begin
            wr_addr_d = payload_addr;
            state_d   = ra_set ? BOTH_ARMED : WR_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wa_set) begin
            mem_we    = 1'b1;
            wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_SIZE'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_SET_RA: begin
          if (payload_ok) begin
            rd_addr_d = payload_addr;
            state_d   = wa_set ? BOTH_ARMED : RD_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (ra_set) begin
            tx_data_d  = rd_word;
            tx_valid_d = 1'b1;
            rd_addr_d  = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_SIZE'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from the same pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Memory write port; a read in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; contents survive rst, and the
    // write is gated so a frame arriving during reset is discarded.
    if (mem_we && !rst) begin
      mem_q[wr_idx] <= payload;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed testbench for spi_ram_ctrl. Two instances share clk/rst: one with
// the default 256-word memory and one with a 16-word memory for range checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows the rising edge which processed the frame.
module tb_spi_ram_ctrl;

  localparam logic [1:0] SET_WA = 2'b00;
  localparam logic [1:0] WR     = 2'b01;
  localparam logic [1:0] SET_RA = 2'b10;
  localparam logic [1:0] RD     = 2'b11;

  typedef struct packed {
    logic       idle;  // no frame this cycle
    logic [1:0] c;
    logic [7:0] p;
    logic       v;     // expected tx_valid
    logic       e;     // expected err
    logic [7:0] d;     // expected tx_data
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid,   rx_valid16;
  logic [9:0] rx_data,    rx_data16;
  logic       tx_valid,   tx_valid16;
  logic [7:0] tx_data,    tx_data16;
  logic       err,        err16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .err      (err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(8)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid16),
    .rx_data  (rx_data16),
    .tx_valid (tx_valid16),
    .tx_data  (tx_data16),
    .err      (err16)
  );

  // tx_valid and err must never be high together on either instance.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((tx_valid && err) || (tx_valid16 && err16)) begin
        n_fail++;
        $display("FAIL exclusive @%0t: tx_valid=%b err=%b tx_valid16=%b err16=%b, required not both high",
                 $time, tx_valid, err, tx_valid16, err16);
      end
    end
  end

  // Present one frame (or an idle cycle) to the 256-word instance.
  task automatic step(input vec_t vv);
    rx_valid = !vv.idle;
    rx_data  = vv.idle ? 10'h000 : {vv.c, vv.p};
    @(negedge clk);
  endtask

  // Present one frame (or an idle cycle) to the 16-word instance.
  task automatic step16(input vec_t vv);
    rx_valid16 = !vv.idle;
    rx_data16  = vv.idle ? 10'h000 : {vv.c, vv.p};
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({tx_valid, err, tx_data, tx_valid16, err16, tx_data16} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_initial: got v=%b e=%b d=%02h v16=%b e16=%b d16=%02h, required all zero",
               tx_valid, err, tx_data, tx_valid16, err16, tx_data16);
    end
    @(negedge clk);
    // A SET_WA frame during reset must be discarded.
    step('{1'b0, SET_WA, 8'h30, 1'b0, 1'b0, 8'h00});
    n_checks++;
    if ({tx_valid, err, tx_data} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_frame: got v=%b e=%b d=%02h, required v=0 e=0 d=00", tx_valid, err, tx_data);
    end
    rx_valid = 1'b0;
    rst      = 1'b0;
  endtask

  // Unarmed WR/RD right after reset: both rejected, tx_data stays 00.
  task automatic test_unarmed();
    vec_t vecs [3];
    vecs = '{'{1'b0, WR, 8'h55, 1'b0, 1'b1, 8'h00},
             '{1'b0, RD, 8'h00, 1'b0, 1'b1, 8'h00},
             '{1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00}};
    for (int i = 0; i < 3; i++) begin
      step(vecs[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {vecs[i].v, vecs[i].e, vecs[i].d}) begin
        n_fail++;
        $display("FAIL unarmed[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, vecs[i].v, vecs[i].e, vecs[i].d);
      end
    end
  endtask

  task automatic test_basic();
    vec_t vecs [7];
    vecs = '{'{1'b0, SET_WA, 8'h10, 1'b0, 1'b0, 8'h00},
             '{1'b0, WR,     8'hA5, 1'b0, 1'b0, 8'h00},
             '{1'b0, WR,     8'h3C, 1'b0, 1'b0, 8'h00},
             '{1'b0, SET_RA, 8'h10, 1'b0, 1'b0, 8'h00},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'hA5},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h3C},
             '{1'b1, 2'b00,  8'h00, 1'b0, 1'b0, 8'h3C}};
    for (int i = 0; i < 7; i++) begin
      step(vecs[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {vecs[i].v, vecs[i].e, vecs[i].d}) begin
        n_fail++;
        $display("FAIL basic[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, vecs[i].v, vecs[i].e, vecs[i].d);
      end
    end
  endtask

  // Auto-increment wraps from 0xFF to 0 on the 256-word instance.
  task automatic test_wrap();
    vec_t vecs [7];
    vecs = '{'{1'b0, SET_WA, 8'hFF, 1'b0, 1'b0, 8'h3C},
             '{1'b0, WR,     8'h11, 1'b0, 1'b0, 8'h3C},
             '{1'b0, WR,     8'h22, 1'b0, 1'b0, 8'h3C},
             '{1'b0, SET_RA, 8'hFF, 1'b0, 1'b0, 8'h3C},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h11},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h22},
             '{1'b1, 2'b00,  8'h00, 1'b0, 1'b0, 8'h22}};
    for (int i = 0; i < 7; i++) begin
      step(vecs[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {vecs[i].v, vecs[i].e, vecs[i].d}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, vecs[i].v, vecs[i].e, vecs[i].d);
      end
    end
  endtask

  // 16-word instance: out-of-range addresses rejected, 0x0F wraps to 0.
  task automatic test_range16();
    vec_t vecs [12];
    vecs = '{'{1'b0, SET_WA, 8'h20, 1'b0, 1'b1, 8'h00},
             '{1'b0, WR,     8'h99, 1'b0, 1'b1, 8'h00},
             '{1'b0, SET_WA, 8'h10, 1'b0, 1'b1, 8'h00},
             '{1'b0, SET_WA, 8'h0F, 1'b0, 1'b0, 8'h00},
             '{1'b0, WR,     8'hAB, 1'b0, 1'b0, 8'h00},
             '{1'b0, WR,     8'hCD, 1'b0, 1'b0, 8'h00},
             '{1'b0, SET_RA, 8'h10, 1'b0, 1'b1, 8'h00},
             '{1'b0, RD,     8'h00, 1'b0, 1'b1, 8'h00},
             '{1'b0, SET_RA, 8'h0F, 1'b0, 1'b0, 8'h00},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'hAB},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'hCD},
             '{1'b1, 2'b00,  8'h00, 1'b0, 1'b0, 8'hCD}};
    for (int i = 0; i < 12; i++) begin
      step16(vecs[i]);
      n_checks++;
      if ({tx_valid16, err16, tx_data16} !== {vecs[i].v, vecs[i].e, vecs[i].d}) begin
        n_fail++;
        $display("FAIL range16[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid16, err16, tx_data16, vecs[i].v, vecs[i].e, vecs[i].d);
      end
    end
  endtask

  // Reset mid-sequence clears outputs at once but keeps memory contents.
  task automatic test_reset_mid();
    vec_t pre [4];
    vec_t post [4];
    pre  = '{'{1'b0, SET_WA, 8'h05, 1'b0, 1'b0, 8'h22},
             '{1'b0, WR,     8'h77, 1'b0, 1'b0, 8'h22},
             '{1'b0, SET_RA, 8'h05, 1'b0, 1'b0, 8'h22},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h77}};
    post = '{'{1'b0, RD,     8'h00, 1'b0, 1'b1, 8'h00},
             '{1'b0, SET_RA, 8'h05, 1'b0, 1'b0, 8'h00},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h77},
             '{1'b1, 2'b00,  8'h00, 1'b0, 1'b0, 8'h77}};
    for (int i = 0; i < 4; i++) begin
      step(pre[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {pre[i].v, pre[i].e, pre[i].d}) begin
        n_fail++;
        $display("FAIL reset_mid_pre[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, pre[i].v, pre[i].e, pre[i].d);
      end
    end
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_valid, err, tx_data} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got v=%b e=%b d=%02h, required v=0 e=0 d=00", tx_valid, err, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(post[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {post[i].v, post[i].e, post[i].d}) begin
        n_fail++;
        $display("FAIL reset_mid_post[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, post[i].v, post[i].e, post[i].d);
      end
    end
  endtask

  // Five frames on consecutive cycles, then one idle cycle.
  task automatic test_back_to_back();
    vec_t vecs [6];
    vecs = '{'{1'b0, SET_WA, 8'h00, 1'b0, 1'b0, 8'h77},
             '{1'b0, WR,     8'h01, 1'b0, 1'b0, 8'h77},
             '{1'b0, WR,     8'h02, 1'b0, 1'b0, 8'h77},
             '{1'b0, SET_RA, 8'h00, 1'b0, 1'b0, 8'h77},
             '{1'b0, RD,     8'h00, 1'b1, 1'b0, 8'h01},
             '{1'b1, 2'b00,  8'h00, 1'b0, 1'b0, 8'h01}};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i]);
      n_checks++;
      if ({tx_valid, err, tx_data} !== {vecs[i].v, vecs[i].e, vecs[i].d}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%b e=%b d=%02h, required v=%b e=%b d=%02h",
                 i, tx_valid, err, tx_data, vecs[i].v, vecs[i].e, vecs[i].d);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 10'h000;
    rx_valid16 = 1'b0;
    rx_data16  = 10'h000;
    test_reset();
    test_unarmed();
    test_basic();
    test_wrap();
    test_range16();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 8-bit memory words; legal range 2..256.
REQ-002 Parameter ADDR_SIZE, default 8: address register width; the design SHALL require MEM_DEPTH <= 2**ADDR_SIZE.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe from the SPI serial-to-parallel stage: rx_data is a complete frame.
REQ-006 rx_data  input  10  frame: [9:8] command, [7:0] payload.
REQ-007 tx_valid  output  1  one-cycle strobe: tx_data holds a new read word.
REQ-008 tx_data  output  8  last word read from memory.
REQ-009 err  output  1  one-cycle strobe: a frame was rejected.

Function
REQ-010 Frames SHALL be decoded only in cycles with rx_valid=1; rx_data SHALL be ignored otherwise.
REQ-011 Cmd 00 (SET_WA): wr_addr <= payload, wa_set <= 1.
REQ-012 Cmd 01 (WR_DATA): if wa_set, mem[wr_addr] <= payload and wr_addr increments; else no write, err=1 next cycle.
REQ-013 Cmd 10 (SET_RA): rd_addr <= payload, ra_set <= 1.
REQ-014 Cmd 11 (RD_DATA): if ra_set, tx_data <= mem[rd_addr], tx_valid=1 for exactly the next cycle, rd_addr increments; else err=1 next cycle, tx_data unchanged.
REQ-015 Address payload >= MEM_DEPTH: frame rejected, err=1 next cycle, address register and set flag unchanged.
REQ-016 Auto-increment SHALL wrap from MEM_DEPTH-1 to 0.
REQ-017 Latency: every response (memory write, tx_valid, err) SHALL be visible in the cycle following the rx_valid edge (one clock).
REQ-018 tx_data SHALL hold its value between reads.
REQ-019 tx_valid and err SHALL never be high in the same cycle.
REQ-020 Back-to-back rx_valid in consecutive cycles SHALL each be processed; no frame is dropped.
REQ-021 Read of the address written in the same cycle SHALL return the old contents (read-before-write).
REQ-022 Internal FSM states: IDLE, WR_ARMED (wa_set only), RD_ARMED (ra_set only), BOTH_ARMED.
REQ-023 FSM transitions occur only on a valid, in-range SET_WA or SET_RA; no command returns the FSM to IDLE except rst.

Reset
REQ-024 While rst=1: tx_valid=0, err=0, tx_data=8'h00, wr_addr=0, rd_addr=0, wa_set=0, ra_set=0, FSM=IDLE, all independent of clk.
REQ-025 Memory contents SHALL NOT be cleared by rst.
REQ-026 A frame whose rx_valid coincides with rst=1 SHALL be discarded.
REQ-027 After rst deasserts, the first rx_valid edge SHALL be processed normally.

Verification
REQ-028 SET_WA 0x10, WR_DATA 0xA5, WR_DATA 0x3C, SET_RA 0x10, RD_DATA x2 -> tx_data 0xA5 then 0x3C, tx_valid one cycle each, err never high.
REQ-029 After reset, WR_DATA 0x55 then RD_DATA -> err pulses twice, tx_valid stays 0, tx_data stays 0x00.
REQ-030 MEM_DEPTH=256: SET_WA 0xFF, WR_DATA 0x11, WR_DATA 0x22; SET_RA 0xFF, RD_DATA x2 -> 0x11 then 0x22 (wrap to addr 0).
REQ-031 MEM_DEPTH=16: SET_WA 0x20 -> err pulse; following WR_DATA -> err pulse (wa_set still 0).
REQ-032 Assert rst mid-sequence after SET_WA 0x05/WR_DATA 0x77 -> outputs zero immediately; after release, SET_RA 0x05, RD_DATA -> 0x77 (memory retained).
REQ-033 Five frames on consecutive cycles (SET_WA 0, WR 1, WR 2, SET_RA 0, RD) -> tx_data 0x01, tx_valid high exactly one cycle after the fifth frame.
